// File: rtl/uart_result_tx.sv
// Serial result reporter: sends 'M' + 9-bit row (3 bytes) or 'N' (1 byte) as 8N1 frames,
// then waits for the requester to drop its code before accepting another request.
module uart_result_tx #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] UARTsend,
  input  logic [8:0] matchRow,
  output logic       UARTtx,
  output logic       UARTsendComplete,
  output logic       busy
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] START    = 3'd1;
  localparam logic [2:0] DATA     = 3'd2;
  localparam logic [2:0] STOP     = 3'd3;
  localparam logic [2:0] DONE     = 3'd4;
  localparam logic [2:0] WAIT_OFF = 3'd5;

  localparam logic [1:0] OFF       = 2'd0;
  localparam logic [1:0] MATCH     = 2'd1;
  localparam logic [1:0] NOT_MATCH = 2'd2;

  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

  logic [2:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [1:0]  byte_q, byte_d;
  logic [1:0]  code_q, code_d;
  logic [8:0]  row_q, row_d;
  logic        tx_q, tx_d;
  logic [7:0]  cur_byte;
  logic        last_byte;
  logic        bit_end;

  assign bit_end = (cnt_q == BIT_LAST);

  // Byte currently on the wire, chosen from the latched code and row.
  always_comb begin
    cur_byte = 8'h4E;
    if (code_q == MATCH) begin
      case (byte_q)
        2'd0:    cur_byte = 8'h4D;
        2'd1:    cur_byte = {7'd0, row_q[8]};
        default: cur_byte = row_q[7:0];
      endcase
    end
  end

  assign last_byte = (code_q != MATCH) || (byte_q == 2'd2);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    code_d  = code_q;
    row_d   = row_q;
    tx_d    = tx_q;
    case (state_q)
      IDLE: begin
        if (UARTsend == MATCH || UARTsend == NOT_MATCH) begin
          state_d = START;
          code_d  = UARTsend;
          row_d   = matchRow;
          cnt_d   = '0;
          bit_d   = '0;
          byte_d  = '0;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = DATA;
          tx_d    = cur_byte[0];
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = cur_byte[bit_q + 3'd1];
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (last_byte) begin
            state_d = DONE;
            tx_d    = 1'b1;
          end else begin
            // Next start bit follows the stop bit with no idle gap.
            byte_d  = byte_q + 2'd1;
            state_d = START;
            tx_d    = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DONE: begin
        state_d = WAIT_OFF;
      end
      WAIT_OFF: begin
        if (UARTsend == OFF) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      code_q  <= '0;
      row_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      code_q  <= code_d;
      row_q   <= row_d;
      tx_q    <= tx_d;
    end
  end

  assign UARTtx           = tx_q;
  assign UARTsendComplete = (state_q == DONE);
  assign busy             = (state_q != IDLE) && (state_q != WAIT_OFF);

endmodule

// File: tb/tb_uart_result_tx.sv
// Directed bench for uart_result_tx at 4 clocks per bit; outputs sampled on the falling edge.
module tb_uart_result_tx;

  localparam int unsigned Cpb = 4;
  localparam int FrameCycles = 10 * Cpb;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] UARTsend;
  logic [8:0] matchRow;
  logic       UARTtx;
  logic       UARTsendComplete;
  logic       busy;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  uart_result_tx #(.CLKS_PER_BIT(Cpb)) dut (
    .clock            (clock),
    .reset            (reset),
    .UARTsend         (UARTsend),
    .matchRow         (matchRow),
    .UARTtx           (UARTtx),
    .UARTsendComplete (UARTsendComplete),
    .busy             (busy)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Line idle: tx high, not busy, no complete pulse, for n cycles.
  task automatic idle_check(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      check({tag, "_tx"}, 16'(UARTtx), 16'd1);
      check({tag, "_busy"}, 16'(busy), 16'd0);
      check({tag, "_cmp"}, 16'(UARTsendComplete), 16'd0);
    end
  endtask

  // Checks every cycle of a message; returns early after stop_at cycles (0 = full message,
  // which then also checks the complete pulse). scramble rewrites matchRow during byte 0.
  task automatic check_msg(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input int nbytes, input int stop_at, input bit scramble);
    logic [7:0] bytes [3];
    logic [7:0] b;
    int bn;
    logic exp;
    bytes[0] = b0;
    bytes[1] = b1;
    bytes[2] = b2;
    for (int c = 0; c < nbytes * FrameCycles; c++) begin
      @(negedge clock);
      b  = bytes[c / FrameCycles];
      bn = (c % FrameCycles) / Cpb;
      if (bn == 0) exp = 1'b0;
      else if (bn == 9) exp = 1'b1;
      else exp = b[bn - 1];
      check($sformatf("msg_tx_c%0d", c), 16'(UARTtx), 16'(exp));
      check($sformatf("msg_busy_c%0d", c), 16'(busy), 16'd1);
      check($sformatf("msg_cmp_c%0d", c), 16'(UARTsendComplete), 16'd0);
      if (scramble && c == 2) matchRow = 9'd7;
      if (c + 1 == stop_at) return;
    end
    @(negedge clock);
    check("done_cmp", 16'(UARTsendComplete), 16'd1);
    check("done_tx", 16'(UARTtx), 16'd1);
    check("done_busy", 16'(busy), 16'd1);
  endtask

  initial begin
    reset    = 1'b0;
    UARTsend = 2'd0;
    matchRow = 9'd0;
    repeat (3) @(negedge clock);
    check("rst_tx", 16'(UARTtx), 16'd1);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_cmp", 16'(UARTsendComplete), 16'd0);
    reset = 1'b1;
    idle_check("idle", 3);

    // NOT_MATCH: single 'N' frame, complete 40 cycles after first start-bit cycle.
    UARTsend = 2'd2;
    check_msg(8'h4E, 8'h00, 8'h00, 1, 0, 1'b0);
    UARTsend = 2'd0;
    idle_check("nm_after", 4);

    // MATCH row 300 -> 'M', 0x01, 0x2C; row changed to 7 mid-message must not matter.
    matchRow = 9'd300;
    UARTsend = 2'd1;
    check_msg(8'h4D, 8'h01, 8'h2C, 3, 0, 1'b1);
    // Request held past the pulse must not retrigger.
    idle_check("hold", 5);
    UARTsend = 2'd0;
    idle_check("off", 2);

    // Reset during data bits of byte 1 aborts at once.
    matchRow = 9'd300;
    UARTsend = 2'd1;
    check_msg(8'h4D, 8'h01, 8'h2C, 3, 50, 1'b0);
    reset    = 1'b0;
    UARTsend = 2'd2;
    #1;
    check("abort_tx", 16'(UARTtx), 16'd1);
    check("abort_busy", 16'(busy), 16'd0);
    check("abort_cmp", 16'(UARTsendComplete), 16'd0);
    idle_check("in_rst", 3);
    reset = 1'b1;
    // Request held through reset release triggers at the first edge.
    check_msg(8'h4E, 8'h00, 8'h00, 1, 0, 1'b0);
    UARTsend = 2'd0;
    idle_check("post", 3);

    // Reserved code is ignored.
    UARTsend = 2'd3;
    idle_check("rsv", 50);
    UARTsend = 2'd0;
    idle_check("end", 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_result_tx.md
UART_RESULT_TX -- requirements
Module: uart_result_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, is the clock cycles per UART bit (50 MHz / 115200 baud); legal range 2..65535.
REQ-002 Port clock  input  1  is the single clock; all state updates on its rising edge.
REQ-003 Port reset  input  1  is the asynchronous, active-low reset.
REQ-004 Port UARTsend  input  2  is the result request code from the control unit: 2'd0 OFF, 2'd1 MATCH, 2'd2 NOT_MATCH, 2'd3 reserved.
REQ-005 Port matchRow  input  9  is the matched row index (0..379), valid whenever UARTsend is MATCH.
REQ-006 Port UARTtx  output  1  is the serial line: 8N1, LSB first, idle high.
REQ-007 Port UARTsendComplete  output  1  is a one-cycle pulse marking the end of the full message.
REQ-008 Port busy  output  1  is high from trigger until the complete pulse, inclusive.

Function
REQ-009 States: IDLE, START, DATA, STOP, DONE, WAIT_OFF.
REQ-010 Trigger: in IDLE, at a rising edge with UARTsend equal to MATCH or NOT_MATCH, the block latches code and matchRow and enters START.
REQ-011 UARTsend equal to 2'd3 or OFF in IDLE causes no action.
REQ-012 MATCH message: three bytes in order, 0x4D ('M'), {7'd0, row[8]}, row[7:0], using the latched row.
REQ-013 NOT_MATCH message: one byte, 0x4E ('N').
REQ-014 Each byte frame is start bit 0, eight data bits LSB first, and stop bit 1.
REQ-015 Each bit holds UARTtx for exactly CLKS_PER_BIT cycles, counted by a bit-period counter of at least 16 bits.
REQ-016 UARTtx goes low on the first cycle after the trigger edge.
REQ-017 Bytes are sent back-to-back with no idle gap; the next start bit directly follows the previous stop bit.
REQ-018 Message length is 30*CLKS_PER_BIT cycles for MATCH and 10*CLKS_PER_BIT cycles for NOT_MATCH.
REQ-019 After the last stop bit period, the block enters DONE and UARTsendComplete is high for exactly that one cycle; UARTtx stays 1.
REQ-020 From DONE the block goes to WAIT_OFF and stays there until UARTsend equals OFF, then returns to IDLE.
REQ-021 WAIT_OFF prevents retransmission, because the requester drops its code one cycle after the complete pulse.
REQ-022 Changes on UARTsend or matchRow while busy are ignored; the latched values govern the whole message.
REQ-023 UARTtx is driven from a register, so it is glitch-free.
REQ-024 UARTsendComplete is never asserted outside DONE.

Reset
REQ-025 While reset is low: state is IDLE, UARTtx is 1, UARTsendComplete is 0, busy is 0, and the counters and latched code/row are 0.
REQ-026 Reset assertion mid-frame aborts the message immediately: UARTtx returns to 1 asynchronously and no complete pulse is issued.
REQ-027 After reset release, a request held on UARTsend is treated as a new trigger at the first clock edge.

Verification (CLKS_PER_BIT = 4)
REQ-028 NOT_MATCH, held until complete and then set to OFF -> UARTtx sequence 0,0,1,1,1,0,0,1,0,1 (4 cycles each); complete pulse once, 40 cycles after the first start-bit cycle; busy is low afterwards.
REQ-029 MATCH with matchRow=300 -> bytes 0x4D, 0x01, 0x2C back-to-back over 120 cycles; one complete pulse.
REQ-030 UARTsend held at MATCH for 5 cycles past the complete pulse -> no second start bit; UARTtx stays 1 until OFF followed by a new request.
REQ-031 matchRow changed from 300 to 7 during byte 0 -> bytes transmitted are still 0x01, 0x2C.
REQ-032 Reset asserted during the data bits of byte 1 -> UARTtx=1 and busy=0 immediately; no complete pulse; a fresh NOT_MATCH request afterwards transmits 0x4E correctly.
REQ-033 UARTsend=2'd3 for 50 cycles -> UARTtx stays 1, busy stays 0, no complete pulse.
